// File: rtl/store_align_unit.sv
// Store alignment and SRAM-like write handshake for the MEM stage.
// Replicates store data across byte lanes, builds strobes, and raises AdES on misalignment.
module store_align_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        st_op,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic              flush,
    output logic              st_done,
    output logic              st_ades,
    output logic              st_buserr,
    output logic [ADDR_W-1:0] st_badvaddr,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                drop_q;
    logic                data_req_q;
    logic [1:0]          data_size_q;
    logic [ADDR_W-1:0]   data_addr_q;
    logic [3:0]          data_wstrb_q;
    logic [31:0]         data_wdata_q;
    logic                st_done_q;
    logic                st_ades_q;
    logic                st_buserr_q;
    logic [ADDR_W-1:0]   st_badvaddr_q;

    logic [1:0]          size_c;
    logic [3:0]          wstrb_c;
    logic [31:0]         wdata_c;
    logic                misalign_c;
    logic                timeout_c;
    logic                suppress_c;

    // Lane decode of the incoming request; op 11 behaves as SW.
    always_comb begin
        size_c     = 2'd2;
        wstrb_c    = 4'b1111;
        wdata_c    = st_data;
        misalign_c = (st_addr[1:0] != 2'b00);
        case (st_op)
            2'b00: begin
                size_c     = 2'd0;
                wstrb_c    = 4'b0001 << st_addr[1:0];
                wdata_c    = {4{st_data[7:0]}};
                misalign_c = 1'b0;
            end
            2'b01: begin
                size_c     = 2'd1;
                wstrb_c    = st_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{st_data[15:0]}};
                misalign_c = st_addr[0];
            end
            default: ;
        endcase
    end

    assign timeout_c  = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign suppress_c = drop_q || flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            drop_q        <= 1'b0;
            data_req_q    <= 1'b0;
            data_size_q   <= '0;
            data_addr_q   <= '0;
            data_wstrb_q  <= '0;
            data_wdata_q  <= '0;
            st_done_q     <= 1'b0;
            st_ades_q     <= 1'b0;
            st_buserr_q   <= 1'b0;
            st_badvaddr_q <= '0;
        end else begin
            st_done_q     <= 1'b0;
            st_ades_q     <= 1'b0;
            st_buserr_q   <= 1'b0;
            st_badvaddr_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (st_valid && !flush) begin
                        if (misalign_c) begin
                            state_q       <= S_ERR;
                            st_done_q     <= 1'b1;
                            st_ades_q     <= 1'b1;
                            st_badvaddr_q <= st_addr;
                        end else begin
                            state_q      <= S_REQ;
                            data_req_q   <= 1'b1;
                            data_size_q  <= size_c;
                            data_addr_q  <= st_addr;
                            data_wstrb_q <= wstrb_c;
                            data_wdata_q <= wdata_c;
                            drop_q       <= 1'b0;
                        end
                    end
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                S_REQ: begin
                    // An accepted handshake cannot be cancelled, so a flush only marks it dropped.
                    if (data_addr_ok) begin
                        state_q    <= S_WAIT;
                        data_req_q <= 1'b0;
                        cnt_q      <= '0;
                        drop_q     <= flush;
                    end else if (flush) begin
                        state_q    <= S_IDLE;
                        data_req_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        state_q   <= S_IDLE;
                        st_done_q <= !suppress_c;
                        drop_q    <= 1'b0;
                    end else if (timeout_c) begin
                        state_q     <= S_IDLE;
                        st_done_q   <= !suppress_c;
                        st_buserr_q <= !suppress_c;
                        drop_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (flush) begin
                            drop_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign st_ready    = (state_q == S_IDLE) && !rst;
    assign st_done     = st_done_q;
    assign st_ades     = st_ades_q;
    assign st_buserr   = st_buserr_q;
    assign st_badvaddr = st_badvaddr_q;
    assign data_req    = data_req_q;
    assign data_wr     = data_req_q;
    assign data_size   = data_size_q;
    assign data_addr   = data_addr_q;
    assign data_wstrb  = data_wstrb_q;
    assign data_wdata  = data_wdata_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: expected completions are queued at issue
// and matched by a monitor when st_done pulses.
module tb_store_align_unit;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        flush;
    logic        st_done;
    logic        st_ades;
    logic        st_buserr;
    logic [31:0] st_badvaddr;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    store_align_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_op        (st_op),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .flush        (flush),
        .st_done      (st_done),
        .st_ades      (st_ades),
        .st_buserr    (st_buserr),
        .st_badvaddr  (st_badvaddr),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok)
    );

    typedef struct {
        int          cmin;
        int          cmax;
        bit          ades;
        bit          buserr;
        logic [31:0] bad;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Completion monitor: every st_done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("flags_exclusive", 32'(st_ades & st_buserr), 32'd0);
            if (st_done === 1'b1) begin
                chk("done_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle_in_window", 32'((cyc >= e.cmin) && (cyc <= e.cmax)), 32'd1);
                    chk("done_ades", 32'(st_ades), 32'(e.ades));
                    chk("done_buserr", 32'(st_buserr), 32'(e.buserr));
                    chk("done_badvaddr", st_badvaddr, e.bad);
                end
            end else begin
                chk("idle_flags_low", {30'd0, st_ades, st_buserr}, 32'd0);
            end
        end
    end

    task automatic push_exp(input int cmin, input int cmax, input bit ades, input bit buserr,
                            input logic [31:0] bad);
        exp_t e;
        e.cmin = cmin; e.cmax = cmax; e.ades = ades; e.buserr = buserr; e.bad = bad;
        exp_q.push_back(e);
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1; st_op = op; st_addr = a; st_data = d;
        step();
        // Scramble request inputs so the bench sees whether fields were latched.
        st_valid = 1'b0; st_op = 2'($urandom); st_addr = $urandom; st_data = $urandom;
    endtask

    task automatic chk_bus(input logic [1:0] esz, input logic [31:0] ea, input logic [3:0] estrb,
                           input logic [31:0] ewd);
        chk("req_high", 32'(data_req), 32'd1);
        chk("wr_high", 32'(data_wr), 32'd1);
        chk("size", 32'(data_size), 32'(esz));
        chk("addr", data_addr, ea);
        chk("wstrb", 32'(data_wstrb), 32'(estrb));
        chk("wdata", data_wdata, ewd);
        chk("busy_not_ready", 32'(st_ready), 32'd0);
    endtask

    // Aligned store with addr_ok after aok extra REQ cycles and data_ok after dok WAIT cycles.
    task automatic store_ok(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] esz, input logic [3:0] estrb, input logic [31:0] ewd,
                            input int aok, input int dok, input bit stray);
        int acc;
        chk("ready_before", 32'(st_ready), 32'd1);
        acc = cyc;
        push_exp(acc + 3 + aok + dok, acc + 3 + aok + dok, 1'b0, 1'b0, 32'd0);
        drive_req(op, a, d);
        for (int i = 0; i <= aok; i++) begin
            chk_bus(esz, a, estrb, ewd);
            if (i == aok) begin
                data_addr_ok = 1'b1;
                data_data_ok = stray;
            end
            step();
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
        end
        chk("wait_req_low", 32'(data_req), 32'd0);
        chk("wait_wr_low", 32'(data_wr), 32'd0);
        for (int i = 0; i < dok; i++) step();
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        chk("ready_after", 32'(st_ready), 32'd1);
    endtask

    initial begin
        int acc;
        bit seen;
        rst = 1'b1; st_valid = 1'b0; st_op = 2'd0; st_addr = 32'd0; st_data = 32'd0;
        flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        step(); step();
        chk("rst_ready", 32'(st_ready), 32'd0);
        chk("rst_done", 32'(st_done), 32'd0);
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_wstrb", 32'(data_wstrb), 32'd0);
        chk("rst_wdata", data_wdata, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        step();
        chk("post_rst_ready", 32'(st_ready), 32'd1);

        store_ok(2'b00, 32'h1000_0003, 32'hAABB_CCDD, 2'd0, 4'b1000, 32'hDDDD_DDDD, 0, 0, 1'b0);
        store_ok(2'b01, 32'h1000_0002, 32'h1234_5678, 2'd1, 4'b1100, 32'h5678_5678, 0, 0, 1'b1);
        store_ok(2'b10, 32'h1000_0000, 32'h1234_5678, 2'd2, 4'b1111, 32'h1234_5678, 0, 1, 1'b0);
        store_ok(2'b00, 32'h2000_0001, 32'h0000_00A5, 2'd0, 4'b0010, 32'hA5A5_A5A5, 1, 0, 1'b0);
        store_ok(2'b01, 32'h2000_0000, 32'hFFFF_BEEF, 2'd1, 4'b0011, 32'hBEEF_BEEF, 0, 0, 1'b0);
        store_ok(2'b11, 32'h3000_0004, 32'hCAFE_F00D, 2'd2, 4'b1111, 32'hCAFE_F00D, 5, 2, 1'b0);

        // Misaligned SW and SH: AdES one cycle after acceptance, no bus request.
        acc = cyc;
        push_exp(acc + 1, acc + 1, 1'b1, 1'b0, 32'h1000_0006);
        drive_req(2'b10, 32'h1000_0006, 32'h1111_2222);
        chk("ades_no_req", 32'(data_req), 32'd0);
        chk("ades_not_ready", 32'(st_ready), 32'd0);
        step();
        chk("ades_back_idle", 32'(st_ready), 32'd1);
        chk("ades_no_req2", 32'(data_req), 32'd0);
        acc = cyc;
        push_exp(acc + 1, acc + 1, 1'b1, 1'b0, 32'h4000_0001);
        drive_req(2'b01, 32'h4000_0001, 32'h3333_4444);
        chk("sh_ades_no_req", 32'(data_req), 32'd0);
        step();

        // Flush together with st_valid in IDLE: request ignored.
        flush = 1'b1;
        drive_req(2'b10, 32'h5000_0000, 32'h5555_5555);
        flush = 1'b0;
        chk("flush_idle_no_req", 32'(data_req), 32'd0);
        chk("flush_idle_ready", 32'(st_ready), 32'd1);

        // Flush in REQ without addr_ok: dropped straight back to IDLE.
        drive_req(2'b10, 32'h6000_0000, 32'h6666_6666);
        chk_bus(2'd2, 32'h6000_0000, 4'b1111, 32'h6666_6666);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_req_idle", 32'(st_ready), 32'd1);
        chk("flush_req_low", 32'(data_req), 32'd0);
        step(); step();

        // Flush with addr_ok: WAIT entered, completion suppressed.
        drive_req(2'b10, 32'h7000_0000, 32'h7777_7777);
        flush = 1'b1;
        data_addr_ok = 1'b1;
        step();
        flush = 1'b0;
        data_addr_ok = 1'b0;
        chk("flush_aok_wait_busy", 32'(st_ready), 32'd0);
        chk("flush_aok_req_low", 32'(data_req), 32'd0);
        step();
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        chk("flush_aok_idle", 32'(st_ready), 32'd1);
        step(); step();

        // Timeout: data_ok never arrives in time; bus error, then stray data_ok ignored.
        acc = cyc;
        push_exp(acc + 5, acc + 8, 1'b0, 1'b1, 32'd0);
        drive_req(2'b10, 32'h8000_0000, 32'h8888_8888);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (st_done === 1'b1) seen = 1'b1;
            else step();
        end
        chk("timeout_done_seen", 32'(seen), 32'd1);
        step(); step();
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        step(); step();
        chk("timeout_idle", 32'(st_ready), 32'd1);

        // Reset during WAIT: silent abandon.
        drive_req(2'b10, 32'h9000_0000, 32'h9999_9999);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_wait_ready", 32'(st_ready), 32'd0);
        chk("rst_wait_req", 32'(data_req), 32'd0);
        chk("rst_wait_addr", data_addr, 32'd0);
        chk("rst_wait_done", 32'(st_done), 32'd0);
        rst = 1'b0;
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        chk("rst_wait_idle", 32'(st_ready), 32'd1);
        step(); step(); step();

        chk("no_pending_done", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
